// File: rtl/cla_pkg.sv
// Shared definitions for the sequential CLA adder: FSM encodings, the nibble
// width, and a helper that sizes the nibble index counter.
package cla_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index width for a given nibble count; a single-nibble adder still gets a
    // one-bit counter so the register never collapses to zero width.
    function automatic int idx_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder slice. This is purely combinational. All internal
// carries come from generate/propagate terms and do not ripple.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Bitwise generate/propagate, then flattened lookahead carries.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/cla_seq_adder.sv
// Area-minimal wide adder: one cla_4bit slice is stepped across the operand
// nibbles, LSB first, with the inter-nibble carry held in a register.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no operation; ready for start, outputs hold last result
//   ST_RUN  | one nibble per cycle, idx selects the nibble being added
//   ST_DONE | result valid, done pulses; a start here begins the next op
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = idx_width(NIB);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;

    logic               accept;
    logic               idx_last;
    logic [NIB_W-1:0]   a_nib;
    logic [NIB_W-1:0]   b_nib;
    logic [NIB_W-1:0]   cla_sum;
    logic               cla_cout;

    // Select the operand nibbles addressed by the current step.
    always_comb begin
        a_nib    = a_q[NIB_W*int'(idx) +: NIB_W];
        b_nib    = b_q[NIB_W*int'(idx) +: NIB_W];
        idx_last = (idx == IDX_W'(NIB - 1));
    end

    cla_4bit u_cla (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                ready  = 1'b1;
                accept = start;
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (idx_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                ready  = 1'b1;
                done   = 1'b1;
                accept = start;
                state_nxt = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand capture, per-nibble accumulation and final flag update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            idx     <= '0;
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state == ST_RUN) begin
            sum_q[NIB_W*int'(idx) +: NIB_W] <= cla_sum;
            carry_q <= cla_cout;
            if (idx_last) begin
                // The top nibble's MSB is the result sign, so overflow can be
                // judged from the live CLA output without waiting a cycle.
                idx    <= '0;
                cout_q <= cla_cout;
                ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1])
                       && (cla_sum[NIB_W-1] != a_q[WIDTH-1]);
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Result outputs come straight from registers.
    always_comb begin
        sum  = sum_q;
        cout = cout_q;
        ovf  = ovf_q;
    end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed and random checks for cla_seq_adder at WIDTH=16.
module tb_cla_seq_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_checks;
    int n_fails;

    cla_seq_adder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one start and wait (bounded) for done; lat counts edges from E0.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                          output logic [15:0] s, output logic co, output logic ov,
                          output int lat, output int bc);
        @(negedge clk);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        bc  = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) bc++;
        end
        s = sum; co = cout; ov = ovf;
    endtask

    logic [15:0] s;
    logic        co, ov;
    int          lat, bc, pulses, n, m;
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] ref_full;
    logic        ref_ovf;
    logic [15:0] s_at_done;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_busy",  32'(busy),  32'd0);
        check("reset_done",  32'(done),  32'd0);
        check("reset_sum",   32'(sum),   32'd0);
        check("reset_cout",  32'(cout),  32'd0);
        check("reset_ovf",   32'(ovf),   32'd0);
        rst_n = 1'b1;

        // Basic add.
        run_op(16'h1234, 16'h4321, 1'b0, s, co, ov, lat, bc);
        check("basic_lat",  32'(lat), 32'd5);
        check("basic_busy", 32'(bc),  32'd4);
        check("basic_done", 32'(done), 32'd1);
        check("basic_sum",  32'(s),   32'h5555);
        check("basic_cout", 32'(co),  32'd0);
        check("basic_ovf",  32'(ov),  32'd0);
        @(negedge clk);
        check("basic_done_pulse", 32'(done),  32'd0);
        check("basic_idle_ready", 32'(ready), 32'd1);
        check("basic_hold_sum",   32'(sum),   32'h5555);

        // Full carry ripple.
        run_op(16'hFFFF, 16'h0001, 1'b0, s, co, ov, lat, bc);
        check("ripple1_sum",  32'(s),  32'h0000);
        check("ripple1_cout", 32'(co), 32'd1);
        check("ripple1_ovf",  32'(ov), 32'd0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, s, co, ov, lat, bc);
        check("ripple2_sum",  32'(s),  32'hFFFF);
        check("ripple2_cout", 32'(co), 32'd1);
        check("ripple2_ovf",  32'(ov), 32'd0);

        // Signed overflow.
        run_op(16'h7FFF, 16'h0001, 1'b0, s, co, ov, lat, bc);
        check("ovf1_sum",  32'(s),  32'h8000);
        check("ovf1_ovf",  32'(ov), 32'd1);
        check("ovf1_cout", 32'(co), 32'd0);
        run_op(16'h8000, 16'h8000, 1'b0, s, co, ov, lat, bc);
        check("ovf2_sum",  32'(s),  32'h0000);
        check("ovf2_ovf",  32'(ov), 32'd1);
        check("ovf2_cout", 32'(co), 32'd1);

        // Start while RUN is ignored.
        @(negedge clk);
        a = 16'h0005; b = 16'h0003; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h1111; b = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        s_at_done = '0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                pulses++;
                s_at_done = sum;
            end
            @(negedge clk);
        end
        check("runstart_pulses", 32'(pulses),    32'd1);
        check("runstart_sum",    32'(s_at_done), 32'h0008);

        // Reset mid-operation.
        @(negedge clk);
        a = 16'h00FF; b = 16'h0F0F; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_busy",  32'(busy),  32'd0);
        check("midrst_done",  32'(done),  32'd0);
        check("midrst_sum",   32'(sum),   32'd0);
        check("midrst_cout",  32'(cout),  32'd0);
        run_op(16'h0101, 16'h0202, 1'b0, s, co, ov, lat, bc);
        check("midrst_lat",   32'(lat), 32'd5);
        check("midrst_after", 32'(s),   32'h0303);

        // Back-to-back with start held high.
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001;
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_lat", 32'(n),   32'd5);
        check("b2b_first_sum", 32'(sum), 32'h0002);
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_bubble", 32'(busy), 32'd1);
        check("b2b_done_drop", 32'(done), 32'd0);
        check("b2b_sum_clear", 32'(sum),  32'h0000);
        m = 1;
        while (!done && m < 20) begin
            @(negedge clk);
            m++;
        end
        check("b2b_spacing",    32'(m),   32'd5);
        check("b2b_second_sum", 32'(sum), 32'h0100);

        // Random operands against the reference sum.
        for (int t = 0; t < 1000; t++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(1, 0));
            ref_full = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
            ref_ovf  = (ra[15] == rb[15]) && (ref_full[15] != ra[15]);
            run_op(ra, rb, rc, s, co, ov, lat, bc);
            check("rand_lat",  32'(lat), 32'd5);
            check("rand_sum",  32'(s),   32'(ref_full[15:0]));
            check("rand_cout", 32'(co),  32'(ref_full[16]));
            check("rand_ovf",  32'(ov),  32'(ref_ovf));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
